// File: rtl/rv16_dmem_responder.sv
// rv16 data-memory responder: slave end of the rv16 load/store interface.
// Word-organised RAM, programmable wait states, fault detection and a
// combinational debug read port.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for i_mem_read/i_mem_write; captures the request
// S_WAIT | burning WAIT_CYCLES cycles on the captured request
// S_RESP | o_mem_ready high for this one cycle; store commits at its end
module rv16_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_mem_size,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_ready,
  output logic        o_mem_err,
  input  logic [31:0] i_dbg_addr,
  output logic [31:0] o_dbg_rdata
);

  localparam int          IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_read;
  logic        req_write;
  logic [2:0]  req_size;

  logic [31:0] mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the response is formed on the accepting edge, so the
  // decode looks at the live request in IDLE and at the captured one otherwise.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_read;
  logic        cur_write;
  logic [2:0]  cur_size;

  logic [32:0]   diff;
  logic          out_of_range;
  logic          size_ok;
  logic          misalign;
  logic          fault;
  logic [IW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   lane;
  logic [31:0]   load_data;
  logic [31:0]   resp_rdata;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          mem_we;

  // request source select and fault / data-path decode
  always_comb begin
    cur_addr  = (state == S_IDLE) ? i_mem_addr  : req_addr;
    cur_wdata = (state == S_IDLE) ? i_mem_wdata : req_wdata;
    cur_read  = (state == S_IDLE) ? i_mem_read  : req_read;
    cur_write = (state == S_IDLE) ? i_mem_write : req_write;
    cur_size  = (state == S_IDLE) ? i_mem_size  : req_size;

    // bit 32 is the borrow, i.e. the address sits below the base
    diff         = {1'b0, cur_addr} - {1'b0, ADDR_BASE};
    out_of_range = diff[32] || ({1'b0, diff[31:0]} >= SPAN_BYTES);

    size_ok = 1'b0;
    case (cur_size)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = !cur_write;
      default:                size_ok = 1'b0;
    endcase

    misalign = ((cur_size[1:0] == 2'b01) && cur_addr[0]) ||
               ((cur_size[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));

    fault = (cur_read && cur_write) || !size_ok || misalign || out_of_range;

    idx     = diff[IW+1:2];
    rd_word = mem[idx];
    lane    = rd_word >> {cur_addr[1:0], 3'b000};

    case (cur_size)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase

    resp_rdata = (fault || cur_write) ? 32'h0 : load_data;

    wr_data = cur_wdata << {cur_addr[1:0], 3'b000};
    case (cur_size[1:0])
      2'b00:   wr_be = 4'b0001 << cur_addr[1:0];
      2'b01:   wr_be = 4'b0011 << cur_addr[1:0];
      default: wr_be = 4'b1111;
    endcase

    mem_we = (state == S_RESP) && cur_write && !fault;
  end

  // store commit on the edge that ends RESP; unselected lanes keep their value
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // debug read is a raw word index; anything past the array reads as zero
  always_comb begin
    o_dbg_rdata = 32'h0;
    if (i_dbg_addr < 32'(DEPTH_WORDS)) o_dbg_rdata = mem[i_dbg_addr[IW-1:0]];
  end

  // request sequencing with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      req_addr    <= 32'h0;
      req_wdata   <= 32'h0;
      req_read    <= 1'b0;
      req_write   <= 1'b0;
      req_size    <= 3'b000;
      o_mem_ready <= 1'b0;
      o_mem_rdata <= 32'h0;
      o_mem_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_mem_read || i_mem_write) begin
            req_addr  <= i_mem_addr;
            req_wdata <= i_mem_wdata;
            req_read  <= i_mem_read;
            req_write <= i_mem_write;
            req_size  <= i_mem_size;
            wait_cnt  <= WAIT_LOAD;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
            end else begin
              state       <= S_RESP;
              o_mem_ready <= 1'b1;
              o_mem_err   <= fault;
              o_mem_rdata <= resp_rdata;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= S_RESP;
            o_mem_ready <= 1'b1;
            o_mem_err   <= fault;
            o_mem_rdata <= resp_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          o_mem_ready <= 1'b0;
          o_mem_err   <= 1'b0;
          o_mem_rdata <= 32'h0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv16_dmem_responder.sv
// Bench for rv16_dmem_responder: a WAIT_CYCLES=2 instance for most scenarios
// and a WAIT_CYCLES=0 instance for back-to-back traffic.
module tb_rv16_dmem_responder;

  localparam int WAITS = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata, dbg_addr = '0, dbg_rdata;
  logic        m_read = 1'b0, m_write = 1'b0, m_ready, m_err;
  logic [2:0]  m_size = '0;

  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata, b_dbg_addr = '0, b_dbg_rdata;
  logic        b_read = 1'b0, b_write = 1'b0, b_ready, b_err;
  logic [2:0]  b_size = '0;

  int n_checks = 0;
  int n_errors = 0;

  // reference byte store, little-endian, byte address = index
  logic [7:0] mb [0:4*DEPTH-1];

  always #5 clk = ~clk;

  rv16_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .i_mem_addr(m_addr), .i_mem_wdata(m_wdata), .i_mem_read(m_read), .i_mem_write(m_write),
    .i_mem_size(m_size), .o_mem_rdata(m_rdata), .o_mem_ready(m_ready), .o_mem_err(m_err),
    .i_dbg_addr(dbg_addr), .o_dbg_rdata(dbg_rdata)
  );

  rv16_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
    .clk(clk), .rst(rst),
    .i_mem_addr(b_addr), .i_mem_wdata(b_wdata), .i_mem_read(b_read), .i_mem_write(b_write),
    .i_mem_size(b_size), .o_mem_rdata(b_rdata), .o_mem_ready(b_ready), .o_mem_err(b_err),
    .i_dbg_addr(b_dbg_addr), .o_dbg_rdata(b_dbg_rdata)
  );

  // Behavioural model: legality from the access rules, data from the byte store.
  function automatic void model_access(input logic [31:0] a, input logic [31:0] wd,
                                       input logic rd, input logic wr, input logic [2:0] sz,
                                       output logic [31:0] rdata, output logic err);
    int nb;
    logic legal;
    logic [31:0] v;
    nb    = 1 << sz[1:0];
    legal = wr ? (sz == 3'd0 || sz == 3'd1 || sz == 3'd2)
               : (sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || sz == 3'd4 || sz == 3'd5);
    err   = (rd && wr) || !legal || ((a % nb) != 0) || (a >= 32'(4*DEPTH));
    rdata = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mb[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[a + i];
        if (nb < 4 && !sz[2] && v[8*nb-1]) begin
          for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        rdata = v;
      end
    end
  endfunction

  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  // drive one request on dut, wait for ready, release in RESP, step one cycle
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [2:0] sz,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic rdy_after, output logic [31:0] dbg_resp,
                        output logic [31:0] dbg_after);
    @(negedge clk);
    m_addr = a; m_wdata = wd; m_read = rd; m_write = wr; m_size = sz;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (m_ready) begin lat = c; break; end
    end
    rdata = m_rdata; err = m_err; dbg_resp = dbg_rdata;
    @(negedge clk);
    m_read = 1'b0; m_write = 1'b0;
    @(posedge clk); #1;
    rdy_after = m_ready; dbg_after = dbg_rdata;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0", m_ready); end
    n_checks++; if (m_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
    n_checks++; if (m_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", m_err); end
    n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready0 got=%b exp=0", b_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    logic [31:0] rd, dr, da, md; logic er, ra, me; int lat;
    dbg_addr = 32'd4;
    model_access(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, md, me);
    access(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, rd, er, lat, ra, dr, da);
    n_checks++; if (lat != WAITS + 1) begin n_errors++; $display("FAIL sw_latency got=%0d exp=%0d", lat, WAITS + 1); end
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL sw_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    n_checks++; if (ra !== 1'b0) begin n_errors++; $display("FAIL sw_ready_width got=%b exp=0", ra); end
    n_checks++; if (da !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sw_dbg got=%h exp=deadbeef", da); end

    model_access(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, md, me);
    access(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, rd, er, lat, ra, dr, da);
    n_checks++; if (lat != WAITS + 1) begin n_errors++; $display("FAIL lw_latency got=%0d exp=%0d", lat, WAITS + 1); end
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_errors++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rd, er); end

    model_access(32'h11, 32'h80, 1'b0, 1'b1, 3'b000, md, me);
    access(32'h11, 32'h80, 1'b0, 1'b1, 3'b000, rd, er, lat, ra, dr, da);
    n_checks++; if (dr !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sb_dbg_in_resp got=%h exp=deadbeef", dr); end
    n_checks++; if (da !== 32'hDEAD80EF) begin n_errors++; $display("FAIL sb_dbg_after got=%h exp=dead80ef", da); end

    model_access(32'h11, 32'h0, 1'b1, 1'b0, 3'b000, md, me);
    access(32'h11, 32'h0, 1'b1, 1'b0, 3'b000, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    model_access(32'h11, 32'h0, 1'b1, 1'b0, 3'b100, md, me);
    access(32'h11, 32'h0, 1'b1, 1'b0, 3'b100, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'h00000080) begin n_errors++; $display("FAIL lbu got=%h exp=00000080", rd); end
    access(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'hDEAD80EF) begin n_errors++; $display("FAIL lw_after_sb got=%h exp=dead80ef", rd); end
    access(32'h10, 32'h0, 1'b1, 1'b0, 3'b001, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'hFFFF80EF) begin n_errors++; $display("FAIL lh_neg got=%h exp=ffff80ef", rd); end

    model_access(32'h12, 32'h1234, 1'b0, 1'b1, 3'b001, md, me);
    access(32'h12, 32'h1234, 1'b0, 1'b1, 3'b001, rd, er, lat, ra, dr, da);
    access(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'h123480EF) begin n_errors++; $display("FAIL lw_after_sh got=%h exp=123480ef", rd); end
    access(32'h12, 32'h0, 1'b1, 1'b0, 3'b001, rd, er, lat, ra, dr, da);
    n_checks++; if (rd !== 32'h00001234) begin n_errors++; $display("FAIL lh got=%h exp=00001234", rd); end
  endtask

  task automatic test_faults;
    logic [31:0] fa [7] = '{32'h13, 32'h11, 32'h10, 32'h10, 32'h1000, 32'h10, 32'hFFFFFFFC};
    logic [31:0] fw [7] = '{32'h0, 32'hAAAA, 32'h0, 32'h55555555, 32'h0, 32'h77, 32'h0};
    logic        fr [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        fwr[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  fs [7] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010, 3'b100, 3'b010};
    logic [31:0] rd, dr, da, md; logic er, ra, me; int lat;
    dbg_addr = 32'd4;
    for (int i = 0; i < 7; i++) begin
      model_access(fa[i], fw[i], fr[i], fwr[i], fs[i], md, me);
      access(fa[i], fw[i], fr[i], fwr[i], fs[i], rd, er, lat, ra, dr, da);
      n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL fault%0d got err=%b rdata=%h exp err=1 rdata=0", i, er, rd); end
      n_checks++; if (da !== mword(4)) begin n_errors++; $display("FAIL fault%0d_ram got=%h exp=%h", i, da, mword(4)); end
    end
    n_checks++; if (mword(4) !== 32'h123480EF) begin n_errors++; $display("FAIL fault_model_word got=%h exp=123480ef", mword(4)); end
    dbg_addr = 32'd1024; #1;
    n_checks++; if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL dbg_oor got=%h exp=0", dbg_rdata); end
    dbg_addr = 32'h80000004; #1;
    n_checks++; if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL dbg_oor_high got=%h exp=0", dbg_rdata); end
  endtask

  task automatic test_wait_inputs;
    logic [31:0] rd, dr, da, md; logic er, ra, me, got; int lat;
    model_access(32'h20, 32'hA5A5_0020, 1'b0, 1'b1, 3'b010, md, me);
    access(32'h20, 32'hA5A5_0020, 1'b0, 1'b1, 3'b010, rd, er, lat, ra, dr, da);
    model_access(32'h40, 32'h5A5A_0040, 1'b0, 1'b1, 3'b010, md, me);
    access(32'h40, 32'h5A5A_0040, 1'b0, 1'b1, 3'b010, rd, er, lat, ra, dr, da);
    @(negedge clk);
    m_addr = 32'h20; m_read = 1'b1; m_write = 1'b0; m_size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    m_addr = 32'h40; m_write = 1'b1; m_wdata = 32'hFFFF_FFFF; m_size = 3'b000;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (m_ready) begin got = 1'b1; break; end
    end
    rd = m_rdata; er = m_err;
    @(negedge clk);
    m_read = 1'b0; m_write = 1'b0;
    @(posedge clk);
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL wchg_timeout got=%b exp=1", got); end
    n_checks++; if (rd !== 32'hA5A50020 || er !== 1'b0) begin n_errors++; $display("FAIL wchg_data got=%h err=%b exp=a5a50020 err=0", rd, er); end
    dbg_addr = 32'd16; #1;
    n_checks++; if (dbg_rdata !== 32'h5A5A0040) begin n_errors++; $display("FAIL wchg_no_write got=%h exp=5a5a0040", dbg_rdata); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, dr, da, md; logic er, ra, me, got; int lat, seen;
    @(negedge clk);
    m_addr = 32'h10; m_read = 1'b1; m_write = 1'b0; m_size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; m_read = 1'b0;
    #1;
    n_checks++; if (m_ready !== 1'b0 || m_rdata !== 32'h0 || m_err !== 1'b0) begin n_errors++; $display("FAIL rst_wait_outputs got rdy=%b rdata=%h err=%b exp 0", m_ready, m_rdata, m_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (m_ready) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rst_wait_no_ready got=%0d exp=0", seen); end
    access(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, rd, er, lat, ra, dr, da);
    n_checks++; if (lat != WAITS + 1 || rd !== mword(4) || er !== 1'b0) begin n_errors++; $display("FAIL rst_recover got lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h err=0", lat, rd, er, WAITS + 1, mword(4)); end

    model_access(32'h30, 32'h1111_2222, 1'b0, 1'b1, 3'b010, md, me);
    access(32'h30, 32'h1111_2222, 1'b0, 1'b1, 3'b010, rd, er, lat, ra, dr, da);
    @(negedge clk);
    m_addr = 32'h30; m_wdata = 32'h3333_4444; m_write = 1'b1; m_size = 3'b010;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (m_ready) begin got = 1'b1; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL rst_resp_timeout got=%b exp=1", got); end
    #2;
    rst = 1'b1; m_write = 1'b0;
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_errors++; $display("FAIL rst_resp_ready got=%b exp=0", m_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; dbg_addr = 32'd12;
    #1;
    n_checks++; if (dbg_rdata !== mword(12)) begin n_errors++; $display("FAIL rst_resp_no_write got=%h exp=%h", dbg_rdata, mword(12)); end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, dr, da, er_d, md; logic er, ra, me, r, w; logic [2:0] sz; int lat, k;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_access(32'(4*i), wd, 1'b0, 1'b1, 3'b010, md, me);
      access(32'(4*i), wd, 1'b0, 1'b1, 3'b010, rd, er, lat, ra, dr, da);
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      a = 32'h1000 + 32'($urandom_range(0, 15));
      else if (k == 1) a = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
      else             a = 32'($urandom_range(0, 63));
      sz = 3'($urandom_range(0, 7));
      wd = $urandom;
      k  = $urandom_range(0, 3);
      r  = (k != 1);
      w  = (k == 1 || k == 2);
      model_access(a, wd, r, w, sz, er_d, me);
      access(a, wd, r, w, sz, rd, er, lat, ra, dr, da);
      n_checks++;
      if (lat != WAITS + 1 || rd !== er_d || er !== me) begin
        n_errors++;
        $display("FAIL rand%0d a=%h sz=%0d r=%b w=%b got lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h err=%b",
                 i, a, sz, r, w, lat, rd, er, WAITS + 1, er_d, me);
      end
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 32'(i); #1;
      n_checks++; if (dbg_rdata !== mword(i)) begin n_errors++; $display("FAIL rand_ram w%0d got=%h exp=%h", i, dbg_rdata, mword(i)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pre [8];
    int idx;
    for (int i = 0; i < 8; i++) begin
      pre[i] = $urandom;
      @(negedge clk);
      b_addr = 32'(4*i); b_wdata = pre[i]; b_write = 1'b1; b_size = 3'b010;
      @(posedge clk); #1;
      n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL w0_store_latency i=%0d got=%b exp=1", i, b_ready); end
      @(negedge clk);
      b_write = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    b_read = 1'b1; b_size = 3'b010;
    for (int k = 1; k <= 12; k++) begin
      idx = $urandom_range(0, 7);
      b_addr = 32'(4*idx);
      @(posedge clk); #1;
      n_checks++; if (b_ready !== 1'(k % 2)) begin n_errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, b_ready, 1'(k % 2)); end
      if (k % 2 == 1) begin
        n_checks++; if (b_rdata !== pre[idx] || b_err !== 1'b0) begin n_errors++; $display("FAIL b2b_data k=%0d got=%h err=%b exp=%h err=0", k, b_rdata, b_err, pre[idx]); end
      end
      @(negedge clk);
    end
    b_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_faults();
    test_wait_inputs();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before the scenario list completed");
    $fatal(1);
  end

endmodule

// File: doc/rv16_dmem_responder.md
Name: rv16_dmem_responder

Overview:
Data-memory responder for the rv16 pipeline: the slave end of the memory interface driven by rv16_ide_stage.
- Accepts load/store requests (address, write data, read/write strobes, funct3-encoded size).
- Holds a word-organised RAM and returns aligned, sign- or zero-extended load data after a programmable number of wait states.
- Flags misaligned, out-of-range, conflicting or badly sized accesses.
- Exposes a side debug read port so benches can inspect memory contents.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index is addr[31:2].
WAIT_CYCLES, 2, extra cycles between request acceptance and o_mem_ready (0..15).
ADDR_BASE, 32'h0000_0000, byte address of word 0; requests below the base or at/above base+4*DEPTH_WORDS are out of range.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
i_mem_addr  input  32  byte address from requester
i_mem_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
i_mem_read  input  1  load request
i_mem_write  input  1  store request
i_mem_size  input  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
o_mem_rdata  output  32  load result, valid only while o_mem_ready=1
o_mem_ready  output  1  one-cycle completion pulse
o_mem_err  output  1  access fault, valid only while o_mem_ready=1
i_dbg_addr  input  32  word index for debug read
o_dbg_rdata  output  32  combinational read of mem[i_dbg_addr]; 0 if the index is out of range

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: o_mem_ready=0, o_mem_rdata=0, o_mem_err=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, request present (i_mem_read|i_mem_write): capture addr, wdata, read, write and size into request registers. Go to WAIT if WAIT_CYCLES>0, else RESP. Count is loaded with WAIT_CYCLES-1.
- WAIT: decrement the counter; at 0 go to RESP. Live inputs are ignored; only captured values are used.
- RESP: o_mem_ready=1 for exactly this cycle, then IDLE.
- Latency: request seen in IDLE at edge N gives ready high in cycle N+1+WAIT_CYCLES.
- Requester contract: hold the request stable until it samples ready. The responder always spends at least one IDLE cycle after RESP before re-accepting, so a still-asserted strobe in that cycle starts a new access.
- Fault checks, evaluated on captured values and applied in RESP:
  - read and write both set;
  - size not in the legal set (for writes, only 000/001/010 are legal);
  - halfword with addr[0]=1, or word with addr[1:0]!=0;
  - address out of range.
- On fault: o_mem_err=1, o_mem_rdata=0, no RAM write.
- Store without fault: written at the RESP edge, byte lanes selected by addr[1:0]:
  - SB writes lane addr[1:0];
  - SH writes lanes {addr[1],0} and {addr[1],1};
  - SW writes all four lanes;
  - unselected lanes are preserved.
  - o_mem_rdata=0 on a store.
- Load without fault: the word is read from the captured index; the lane is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - o_mem_rdata is registered so it is valid in RESP.
- Reset mid-WAIT or mid-RESP: abandons the access with no write and no ready pulse.
- Debug port: pure combinational, independent of the FSM. A store becomes visible on it the cycle after its RESP edge.
- Widths: internal index width is clog2(DEPTH_WORDS); range compare uses the full 32-bit address minus ADDR_BASE.

Test Plan:
- Reset, WAIT_CYCLES=2: assert rst mid-sim with a load in WAIT -> ready never pulses for that load; all outputs 0 within the same cycle; the next request completes normally.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> each ready pulses exactly 3 cycles after acceptance; LW returns 0xDEADBEEF with err=0; o_dbg_rdata(4)=0xDEADBEEF.
- SB 0x80 @0x11, then reads @0x11 (word at 0x10 holds 0xDEADBEEF) -> LB=0xFFFFFF80, LBU=0x00000080, LW=0xDEAD80EF; SH 0x1234 @0x12 -> LW@0x10=0x123480EF, LH@0x12=0x00001234.
- Faults -> err=1, rdata=0, RAM unchanged on each:
  - LW @0x13;
  - SH @0x11;
  - size=011;
  - read & write together;
  - LW @ADDR_BASE+4*DEPTH_WORDS.
- WAIT_CYCLES=0, back-to-back requests with strobe held high -> ready pulses on every second cycle (RESP, IDLE, RESP...); captured address is taken from the IDLE-cycle sample.
- Request inputs changed during WAIT (addr 0x20 -> 0x40) -> the access completes against 0x20.
